// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external pipelined 32x32->64 unsigned multiplier among N requesters.
// Build option: define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mul_arbiter #(
  parameter int N           = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  output logic [N-1:0]    resp_valid,
  output logic [63:0]     resp_r,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  input  logic [63:0]     mul_r,
  output logic            busy,
  output logic [15:0]     issue_count
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0]        ptr;
  logic                   grant_any;
  logic [ID_W-1:0]        grant_id;
  logic                   transfer;
  logic [MUL_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]        tag_id [MUL_LATENCY];

  // First valid requester searching ptr, ptr+1, ... modulo N.
  always_comb begin
    logic [ID_W:0] slot;
    grant_any = 1'b0;
    grant_id  = '0;
    slot      = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(N)) slot = slot - (ID_W+1)'(N);
      if (!grant_any && req_valid[slot[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = slot[ID_W-1:0];
      end
    end
  end

  // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
  // ready is one-hot or zero, never raised for an idle requester, and held low in reset.
  assign transfer  = grant_any && !reset;
  assign req_ready = transfer ? (N'(1) << grant_id) : '0;
  assign mul_a     = transfer ? req_a[32*grant_id +: 32] : 32'd0;
  assign mul_b     = transfer ? req_b[32*grant_id +: 32] : 32'd0;

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + ID_W'(1);
    end
  end
`endif

  // Tag ids travel alongside their valid bits; only the valids need clearing.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int i = MUL_LATENCY-1; i > 0; i--) tag_id[i] <= tag_id[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid   <= '0;
      resp_valid  <= '0;
      resp_r      <= 64'd0;
      busy        <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      tag_valid[0] <= transfer;
      for (int i = MUL_LATENCY-1; i > 0; i--) tag_valid[i] <= tag_valid[i-1];
      if (tag_valid[MUL_LATENCY-1]) begin
        resp_r     <= mul_r;
        resp_valid <= N'(1) << tag_id[MUL_LATENCY-1];
      end else begin
        resp_valid <= '0;
      end
      busy <= transfer || (|tag_valid);
      if (transfer) issue_count <= issue_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: random and directed traffic against a cycle-level model with a response scoreboard.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 104; // {due cycle[103:72], id[71:64], product[63:0]}

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_r;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [63:0]     mul_r;
  logic            busy;
  logic [15:0]     issue_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int           grant_log[$];
  int           cyc = 0;
  bit           mon_en = 1'b0;
  int           m_ptr = 0;
  logic [15:0]  m_count = 16'd0;
  int           last_x = -1000;
  logic [63:0]  m_resp_r = 64'd0;
  logic [63:0]  mul_pipe [L];

  always #5 clk = ~clk;

  mul_arbiter #(.N(N), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_r(resp_r),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .busy(busy), .issue_count(issue_count)
  );

  // External multiplier with L cycles of latency.
  always @(posedge clk) begin
    mul_pipe[0] <= 64'(mul_a) * 64'(mul_b);
    for (int i = 1; i < L; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_r = mul_pipe[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: grant rule, latency schedule and status, evaluated once per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] exp_ready;
      bit           xfer;
      int           gid;
      logic [W-1:0] front;
      exp_ready = '0;
      xfer = 1'b0;
      gid = 0;
      if (!reset) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++)
          if (!xfer && req_valid[k]) begin xfer = 1'b1; gid = k; end
`else
        for (int k = 0; k < N; k++)
          if (!xfer && req_valid[(m_ptr + k) % N]) begin xfer = 1'b1; gid = (m_ptr + k) % N; end
`endif
        if (xfer) exp_ready[gid] = 1'b1;
      end
      check("ready", 64'(req_ready), 64'(exp_ready));
      check("mul_a", 64'(mul_a), xfer ? 64'(req_a[32*gid +: 32]) : 64'd0);
      check("mul_b", 64'(mul_b), xfer ? 64'(req_b[32*gid +: 32]) : 64'd0);
      if (exp_q.size() > 0 && int'(exp_q[0][103:72]) == cyc) begin
        front = exp_q.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(N'(1) << front[71:64]));
        m_resp_r = front[63:0];
      end else begin
        check("resp_valid", 64'(resp_valid), 64'd0);
      end
      check("resp_r", resp_r, m_resp_r);
      check("busy", 64'(busy), 64'((cyc - last_x) >= 1 && (cyc - last_x) <= L + 1));
      check("issue_count", 64'(issue_count), 64'(m_count));
      if (reset) begin
        exp_q.delete();
        m_ptr = 0;
        m_count = 16'd0;
        last_x = -1000;
        m_resp_r = 64'd0;
      end else if (xfer) begin
        exp_q.push_back({32'(cyc + L + 1), 8'(gid),
                         64'(req_a[32*gid +: 32]) * 64'(req_b[32*gid +: 32])});
        m_ptr = (gid + 1) % N;
        m_count = m_count + 16'd1;
        last_x = cyc;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req_valid = '0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Requesters raise valid at random (or always), holding operands until their transfer.
  task automatic traffic(input int cycles, input bit all_on);
    logic [N-1:0] hs;
    for (int t = 0; t < cycles; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && (all_on || $urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          req_a[32*i +: 32] = rand_op();
          req_b[32*i +: 32] = rand_op();
        end
      end
      @(negedge clk);
      hs = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (hs[i]) grant_log.push_back(i);
      tick();
      req_valid = req_valid & ~hs;
    end
  endtask

  task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string tag);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'(N'(1) << id));
    tick();
    req_valid = '0;
    repeat (L) tick();
    @(negedge clk);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(N'(1) << id));
    check({tag, "_resp_r"}, resp_r, exp);
    check({tag, "_count"}, 64'(issue_count), 64'd1);
    check({tag, "_busy_hi"}, 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;

    single_op(0, 32'h2345_6789, 32'h3456_7891, 64'h2345_6789 * 64'h3456_7891, "single");

    do_reset(2);
    single_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    do_reset(2);
    single_op(3, 32'd0, 32'hFFFF_FFFF, 64'd0, "zero");

    do_reset(2);
    grant_log.delete();
    traffic(8, 1'b1);
    req_valid = '0;
    repeat (L + 3) tick();
    check("rr_len", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      check("rr_grant", 64'(grant_log[k]), 64'd0);
`else
      check("rr_grant", 64'(grant_log[k]), 64'(k % N));
`endif
    end

    do_reset(2);
    a = $urandom;
    b = $urandom;
    req_valid = 4'b0100;
    for (int t = 0; t < 10000; t++) begin
      req_a[64 +: 32] = a;
      req_b[64 +: 32] = b;
      tick();
      a = a + 32'h2345_6789;
      b = b + 32'h3456_7891;
    end
    req_valid = '0;
    repeat (L + 3) tick();

    do_reset(2);
    req_valid = 4'b0011;
    req_a = {4{rand_op()}};
    req_b = {4{rand_op()}};
    tick();
    req_valid = 4'b0010;
    tick();
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_count", 64'(issue_count), 64'd0);
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_ptr", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (L + 3) tick();

    do_reset(2);
    traffic(2000, 1'b0);
    req_valid = '0;
    repeat (L + 3) tick();

    do_reset(2);
    traffic(65537, 1'b1);
    req_valid = '0;
    @(negedge clk);
    check("wrap_count", 64'(issue_count), 64'd1);
    repeat (L + 3) tick();

    check("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
